// File: rtl/hold_until_release_ctrl_if.sv
// Bundles the start/release inputs and the hold/status outputs of hold_until_release_ctrl.
// The slave modport is the controller side. The master modport is the side that drives requests.
interface hold_until_release_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             signal_a;
  logic             signal_c;
  logic             signal_d;
  logic             clr_err;
  logic             signal_b;
  logic             rel_valid;
  logic [1:0]       rel_cause;
  logic [CNT_W-1:0] hold_len;
  logic             timeout_err;
  logic [CNT_W-1:0] sess_cnt;

  modport slave (
    input  signal_a, signal_c, signal_d, clr_err,
    output signal_b, rel_valid, rel_cause, hold_len, timeout_err, sess_cnt
  );

  modport master (
    output signal_a, signal_c, signal_d, clr_err,
    input  signal_b, rel_valid, rel_cause, hold_len, timeout_err, sess_cnt
  );
endinterface

// File: rtl/hold_until_release_ctrl.sv
// Raises signal_b after a start pulse and holds it until release C/D or a MAX_HOLD timeout.
// Reports the release cause, the hold length, a sticky timeout flag and a saturating session count.
module hold_until_release_ctrl #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  hold_until_release_ctrl_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] L_MAX_HOLD = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] L_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_SESS_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic             w_start;
  logic             w_release;
  logic             w_timeout;

  logic             r_signal_b;
  logic             r_rel_valid;
  logic [1:0]       r_rel_cause;
  logic [CNT_W-1:0] r_hold_len;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_sess_cnt;

  // NOTE: every signal gets a default first, so no path through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_start        = 1'b0;
    w_release      = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      // Release inputs are ignored while idle, even when they coincide with a start.
      S_IDLE: begin
        if (bus.signal_a) begin
          w_state_nxt    = S_HOLD;
          w_hold_cnt_nxt = L_CNT_ONE;
          w_start        = 1'b1;
        end
      end
      // Release beats timeout, and timeout beats retrigger.
      S_HOLD: begin
        if (bus.signal_c || bus.signal_d) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
        end else if (r_hold_cnt == L_MAX_HOLD) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end else if (bus.signal_a) begin
          w_hold_cnt_nxt = L_CNT_ONE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + L_CNT_ONE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_hold_cnt    <= '0;
      r_signal_b    <= 1'b0;
      r_rel_valid   <= 1'b0;
      r_rel_cause   <= 2'b00;
      r_hold_len    <= '0;
      r_timeout_err <= 1'b0;
      r_sess_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_signal_b  <= (w_state_nxt == S_HOLD);
      r_rel_valid <= w_release || w_timeout;

      if (w_release) begin
        r_rel_cause <= {bus.signal_d, bus.signal_c};
        r_hold_len  <= r_hold_cnt;
      end else if (w_timeout) begin
        r_rel_cause <= 2'b00;
        r_hold_len  <= L_MAX_HOLD;
      end

      // A timeout on the same edge as clr_err leaves the flag set.
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (bus.clr_err) begin
        r_timeout_err <= 1'b0;
      end

      if (w_start && (r_sess_cnt != L_SESS_MAX)) begin
        r_sess_cnt <= r_sess_cnt + L_CNT_ONE;
      end
    end
  end

  assign bus.signal_b    = r_signal_b;
  assign bus.rel_valid   = r_rel_valid;
  assign bus.rel_cause   = r_rel_cause;
  assign bus.hold_len    = r_hold_len;
  assign bus.timeout_err = r_timeout_err;
  assign bus.sess_cnt    = r_sess_cnt;

endmodule

// File: tb/tb_hold_until_release_ctrl.sv
// Self-checking bench for hold_until_release_ctrl: two instances (16/8 and 3/2) share one stimulus stream.
// Directed scenarios with literal expectations are followed by random stimulus checked every cycle against a behavioural model.
module tb_hold_until_release_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, a, c, d, clr;

  hold_until_release_ctrl_if #(.CNT_W(8)) bus0 ();
  hold_until_release_ctrl_if #(.CNT_W(2)) bus1 ();

  assign bus0.signal_a = a;
  assign bus0.signal_c = c;
  assign bus0.signal_d = d;
  assign bus0.clr_err  = clr;
  assign bus1.signal_a = a;
  assign bus1.signal_c = c;
  assign bus1.signal_d = d;
  assign bus1.clr_err  = clr;

  hold_until_release_ctrl #(.MAX_HOLD(16), .CNT_W(8)) u_dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0)
  );

  hold_until_release_ctrl #(.MAX_HOLD(3), .CNT_W(2)) u_dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks whether a hold is in progress and how many cycles it has lasted.
  typedef struct {
    bit known;
    bit in_hold;
    int elapsed;
    int cause;
    int last_len;
    bit rel;
    bit terr;
    int sess;
  } model_t;

  model_t m0 = '{default: 0};
  model_t m1 = '{default: 0};

  function automatic model_t model_step(input model_t m, input bit irst, input bit ia, input bit ic,
                                        input bit id, input bit iclr, input int max_hold, input int sess_max);
    model_t n = m;
    bit timed_out = 1'b0;
    if (irst) begin
      n = '{default: 0};
      n.known = 1'b1;
      return n;
    end
    if (!m.known) return n;
    n.rel = 1'b0;
    if (!m.in_hold) begin
      if (ia) begin
        n.in_hold = 1'b1;
        n.elapsed = 1;
        n.sess    = (m.sess < sess_max) ? m.sess + 1 : sess_max;
      end
    end else if (ic || id) begin
      n.in_hold  = 1'b0;
      n.rel      = 1'b1;
      n.cause    = 2 * int'(id) + int'(ic);
      n.last_len = m.elapsed;
    end else if (m.elapsed >= max_hold) begin
      n.in_hold  = 1'b0;
      n.rel      = 1'b1;
      n.cause    = 0;
      n.last_len = max_hold;
      timed_out  = 1'b1;
    end else begin
      n.elapsed = ia ? 1 : m.elapsed + 1;
    end
    if (timed_out)  n.terr = 1'b1;
    else if (iclr)  n.terr = 1'b0;
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= model_step(m0, rst, a, c, d, clr, 16, 255);
    m1 <= model_step(m1, rst, a, c, d, clr, 3, 3);
  end

  task automatic compare(input string tag, input model_t m, input logic b, input logic rv,
                         input logic [1:0] rc, input logic [31:0] hl, input logic te, input logic [31:0] sc);
    check({tag, ".signal_b"},    32'(b),  32'(m.in_hold));
    check({tag, ".rel_valid"},   32'(rv), 32'(m.rel));
    check({tag, ".rel_cause"},   32'(rc), 32'(m.cause));
    check({tag, ".hold_len"},    hl,      32'(m.last_len));
    check({tag, ".timeout_err"}, 32'(te), 32'(m.terr));
    check({tag, ".sess_cnt"},    sc,      32'(m.sess));
  endtask

  always @(negedge clk) begin
    if (m0.known) begin
      compare("dut0", m0, bus0.signal_b, bus0.rel_valid, bus0.rel_cause, 32'(bus0.hold_len),
              bus0.timeout_err, 32'(bus0.sess_cnt));
      compare("dut1", m1, bus1.signal_b, bus1.rel_valid, bus1.rel_cause, 32'(bus1.hold_len),
              bus1.timeout_err, 32'(bus1.sess_cnt));
    end
  end

  // Applies inputs for one edge; on return the outputs reflect that edge.
  task automatic cyc(input bit ia, input bit ic, input bit id, input bit iclr, input bit irst);
    a = ia; c = ic; d = id; clr = iclr; rst = irst;
    @(negedge clk);
  endtask

  initial begin
    int n;
    a = 1'b0; c = 1'b0; d = 1'b0; clr = 1'b0; rst = 1'b1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    check("reset.signal_b",  32'(bus0.signal_b),  0);
    check("reset.rel_valid", 32'(bus0.rel_valid), 0);
    check("reset.sess_cnt",  32'(bus0.sess_cnt),  0);
    check("reset.hold_len",  32'(bus0.hold_len),  0);

    // Basic release via C after four hold cycles.
    cyc(1, 0, 0, 0, 0);
    check("basic.start_b", 32'(bus0.signal_b), 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("basic.still_b", 32'(bus0.signal_b), 1);
    cyc(0, 1, 0, 0, 0);
    check("basic.b_low",     32'(bus0.signal_b),  0);
    check("basic.rel_valid", 32'(bus0.rel_valid), 1);
    check("basic.rel_cause", 32'(bus0.rel_cause), 1);
    check("basic.hold_len",  32'(bus0.hold_len),  4);
    check("basic.sess_cnt",  32'(bus0.sess_cnt),  1);
    check("model.hold_len",  32'(m0.last_len),    4);
    cyc(0, 0, 0, 0, 0);
    check("basic.rel_drop",  32'(bus0.rel_valid), 0);
    check("basic.cause_kept", 32'(bus0.rel_cause), 1);

    // C and D together at hold cycle 2.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("both.rel_cause", 32'(bus0.rel_cause), 3);
    check("both.hold_len",  32'(bus0.hold_len),  2);
    check("model.cause",    32'(m0.cause),       3);

    // Timeout with no release.
    cyc(1, 0, 0, 0, 0);
    n = int'(bus0.signal_b);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (bus0.rel_valid) break;
      n += int'(bus0.signal_b);
    end
    check("timeout.high_cycles", 32'(n), 16);
    check("timeout.rel_cause",   32'(bus0.rel_cause),   0);
    check("timeout.hold_len",    32'(bus0.hold_len),    16);
    check("timeout.err",         32'(bus0.timeout_err), 1);
    cyc(0, 0, 0, 1, 0);
    check("timeout.clr", 32'(bus0.timeout_err), 0);

    // Retrigger at hold cycle 10, then timeout 16 edges later.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("retrig.b",        32'(bus0.signal_b), 1);
    check("retrig.sess_cnt", 32'(bus0.sess_cnt), 4);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0, 0);
      n++;
      if (bus0.rel_valid) break;
    end
    check("retrig.edges_to_timeout", 32'(n), 16);
    check("retrig.sess_after", 32'(bus0.sess_cnt), 4);
    cyc(0, 0, 0, 1, 0);

    // Start and release together while holding: release wins, no new hold.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("prio.b_low",     32'(bus0.signal_b),  0);
    check("prio.rel_cause", 32'(bus0.rel_cause), 1);
    cyc(0, 0, 0, 0, 0);
    check("prio.no_restart", 32'(bus0.signal_b), 0);
    check("prio.sess_cnt",   32'(bus0.sess_cnt), 5);

    // Start and release together in idle: the hold starts.
    cyc(1, 1, 0, 0, 0);
    check("idle_ac.b",         32'(bus0.signal_b),  1);
    check("idle_ac.rel_valid", 32'(bus0.rel_valid), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("restart.b",   32'(bus0.signal_b), 1);
    check("restart.ses", 32'(bus0.sess_cnt), 7);

    // Reset at hold cycle 3.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("midrst.b",         32'(bus0.signal_b),  0);
    check("midrst.rel_valid", 32'(bus0.rel_valid), 0);
    check("midrst.sess_cnt",  32'(bus0.sess_cnt),  0);
    cyc(0, 0, 0, 0, 0);
    check("midrst.no_pulse", 32'(bus0.rel_valid), 0);

    // Five sessions: the 2-bit counter sticks at 3.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
    end
    check("sat.sess_cnt_w2", 32'(bus1.sess_cnt), 3);
    check("sat.sess_cnt_w8", 32'(bus0.sess_cnt), 5);

    // Random stimulus, compared against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 5, $urandom_range(0, 199) < 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
